// File: rtl/wakeup_latency_pipeline_pkg.sv
// Shared defaults and helpers for the scheduler wakeup latency pipeline.
package wakeup_latency_pipeline_pkg;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_IQ_ENTRIES = 16;
  localparam int DEF_MAX_LAT    = 4;

  // Map a requested latency onto the supported 1..maxLat window.
  function automatic int clampLat(input int lat, input int maxLat);
    if (lat < 1) return 1;
    if (lat > maxLat) return maxLat;
    return lat;
  endfunction

  // Index width for an array of n entries, never narrower than one bit.
  function automatic int indexWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wakeup_delay_line.sv
// One issue channel's wakeup delay line: slot k fires k+1 cycles after capture.
module wakeup_delay_line
  import wakeup_latency_pipeline_pkg::*;
#(
  parameter int IQ_ENTRIES = DEF_IQ_ENTRIES,
  parameter int IDX_W      = $clog2(IQ_ENTRIES),
  parameter int MAX_LAT    = DEF_MAX_LAT,
  parameter int LAT_W      = $clog2(MAX_LAT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  selected,
  input  logic [IDX_W-1:0]      selectedPtr,
  input  logic [IQ_ENTRIES-1:0] selectedVector,
  input  logic [LAT_W-1:0]      selectedLat,
  output logic [MAX_LAT-1:0]    latBusy,
  output logic                  wakeup,
  output logic [IDX_W-1:0]      wakeupPtr,
  output logic [IQ_ENTRIES-1:0] wakeupVector,
  output logic                  collision
);

  localparam int SLOT_IDX_W = indexWidth(MAX_LAT);

  typedef struct packed {
    logic                  valid;
    logic [IDX_W-1:0]      ptr;
    logic [IQ_ENTRIES-1:0] vector;
  } delaySlot_t;

  localparam int SLOT_W = $bits(delaySlot_t);

  delaySlot_t [MAX_LAT-1:0] slotQ;
  delaySlot_t [MAX_LAT-1:0] slotD;
  logic [MAX_LAT-1:0]       slotValid;
  logic [SLOT_IDX_W-1:0]    insIdx;

  // Gather valid bits; latBusy[k] is the slot that shifts into insertion point k.
  always_comb begin
    for (int k = 0; k < MAX_LAT; k++) begin
      slotValid[k] = slotQ[k].valid;
    end
    latBusy = slotValid >> 1;
  end

  // Clamp the requested latency and flag a select that would land on an occupied slot.
  always_comb begin
    insIdx    = SLOT_IDX_W'(clampLat(int'(selectedLat), MAX_LAT) - 1);
    collision = selected & ~stall & latBusy[insIdx];
  end

  // Next slot contents: flush wins, stall holds, otherwise shift and insert.
  always_comb begin
    slotD = slotQ;
    if (flush) begin
      slotD = '0;
    end else if (!stall) begin
      slotD = slotQ >> SLOT_W;
      if (selected && !latBusy[insIdx]) begin
        slotD[insIdx] = '{valid: 1'b1, ptr: selectedPtr, vector: selectedVector};
      end
    end
  end

  // Slot storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slotQ <= '0;
    end else begin
      slotQ <= slotD;
    end
  end

  // Slot 0 drives the wakeup bus; a stalled cycle presents no wakeup.
  always_comb begin
    wakeup       = slotQ[0].valid & ~stall;
    wakeupPtr    = slotQ[0].ptr;
    wakeupVector = slotQ[0].vector;
  end

endmodule

// File: rtl/wakeup_latency_pipeline.sv
// Per-channel latency-delayed wakeup, one-cycle entry release and sticky collision flag.
module wakeup_latency_pipeline
  import wakeup_latency_pipeline_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int IQ_ENTRIES = DEF_IQ_ENTRIES,
  parameter int IDX_W      = $clog2(IQ_ENTRIES),
  parameter int MAX_LAT    = DEF_MAX_LAT,
  parameter int LAT_W      = $clog2(MAX_LAT + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               stall,
  input  logic                               flush,
  input  logic [NUM_CH-1:0]                  selected,
  input  logic [NUM_CH-1:0][IDX_W-1:0]       selectedPtr,
  input  logic [NUM_CH-1:0][IQ_ENTRIES-1:0]  selectedVector,
  input  logic [NUM_CH-1:0][LAT_W-1:0]       selectedLat,
  output logic [NUM_CH-1:0][MAX_LAT-1:0]     latBusy,
  output logic [NUM_CH-1:0]                  wakeup,
  output logic [NUM_CH-1:0][IDX_W-1:0]       wakeupPtr,
  output logic [NUM_CH-1:0][IQ_ENTRIES-1:0]  wakeupVector,
  output logic [NUM_CH-1:0]                  releaseEntry,
  output logic [NUM_CH-1:0][IDX_W-1:0]       releasePtr,
  output logic                               collisionErr
);

  logic [NUM_CH-1:0] chCollision;
  logic [NUM_CH-1:0] releaseQ;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : gChannel
    wakeup_delay_line #(
      .IQ_ENTRIES(IQ_ENTRIES),
      .IDX_W     (IDX_W),
      .MAX_LAT   (MAX_LAT),
      .LAT_W     (LAT_W)
    ) uDelayLine (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .flush         (flush),
      .selected      (selected[ch]),
      .selectedPtr   (selectedPtr[ch]),
      .selectedVector(selectedVector[ch]),
      .selectedLat   (selectedLat[ch]),
      .latBusy       (latBusy[ch]),
      .wakeup        (wakeup[ch]),
      .wakeupPtr     (wakeupPtr[ch]),
      .wakeupVector  (wakeupVector[ch]),
      .collision     (chCollision[ch])
    );
  end

  // Release registers: capture every non-stalled select, even dropped or flushed ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      releaseQ   <= '0;
      releasePtr <= '0;
    end else if (stall) begin
      releaseQ   <= '0;
    end else begin
      releaseQ   <= selected;
      releasePtr <= selectedPtr;
    end
  end

  // A stalled cycle also withholds the release, which is not retried afterwards.
  always_comb begin
    releaseEntry = releaseQ & {NUM_CH{~stall}};
  end

  // Any channel collision latches the error until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      collisionErr <= 1'b0;
    end else if (|chCollision) begin
      collisionErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wakeup_latency_pipeline.sv
// Scoreboard bench for wakeup_latency_pipeline: stimulus pushes expectations, a monitor pops them.
module tb_wakeup_latency_pipeline;

  localparam int NUM_CH     = 4;
  localparam int IQ_ENTRIES = 16;
  localparam int IDX_W      = 4;
  localparam int MAX_LAT    = 4;
  localparam int LAT_W      = 3;
  localparam int CH_W       = 2;

  logic                              clk;
  logic                              rst;
  logic                              stall;
  logic                              flush;
  logic [NUM_CH-1:0]                 selected;
  logic [NUM_CH-1:0][IDX_W-1:0]      selectedPtr;
  logic [NUM_CH-1:0][IQ_ENTRIES-1:0] selectedVector;
  logic [NUM_CH-1:0][LAT_W-1:0]      selectedLat;
  logic [NUM_CH-1:0][MAX_LAT-1:0]    latBusy;
  logic [NUM_CH-1:0]                 wakeup;
  logic [NUM_CH-1:0][IDX_W-1:0]      wakeupPtr;
  logic [NUM_CH-1:0][IQ_ENTRIES-1:0] wakeupVector;
  logic [NUM_CH-1:0]                 releaseEntry;
  logic [NUM_CH-1:0][IDX_W-1:0]      releasePtr;
  logic                              collisionErr;

  typedef struct {
    int                    cyc;
    logic [IDX_W-1:0]      ptr;
    logic [IQ_ENTRIES-1:0] vec;
  } expect_t;

  expect_t wakeQ[NUM_CH][$];
  expect_t relQ[NUM_CH][$];

  int tests;
  int failed;
  int cyc;
  bit monOn;

  wakeup_latency_pipeline #(
    .NUM_CH    (NUM_CH),
    .IQ_ENTRIES(IQ_ENTRIES),
    .IDX_W     (IDX_W),
    .MAX_LAT   (MAX_LAT),
    .LAT_W     (LAT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .selected      (selected),
    .selectedPtr   (selectedPtr),
    .selectedVector(selectedVector),
    .selectedLat   (selectedLat),
    .latBusy       (latBusy),
    .wakeup        (wakeup),
    .wakeupPtr     (wakeupPtr),
    .wakeupVector  (wakeupVector),
    .releaseEntry  (releaseEntry),
    .releasePtr    (releasePtr),
    .collisionErr  (collisionErr)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle number: a value visible during cycle N was produced by the edge that started N.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clearInputs();
    selected       = '0;
    selectedPtr    = '0;
    selectedVector = '0;
    selectedLat    = '0;
    stall          = 1'b0;
    flush          = 1'b0;
  endtask

  // Drive one select for the current cycle; relAt/wakeAt are hand-computed offsets, 0 = none.
  task automatic applyStimulus(input logic [CH_W-1:0] ch, input logic [IDX_W-1:0] ptr,
                               input logic [LAT_W-1:0] lat, input int relAt, input int wakeAt);
    expect_t e;
    selected[ch]       = 1'b1;
    selectedPtr[ch]    = ptr;
    selectedVector[ch] = IQ_ENTRIES'(1) << ptr;
    selectedLat[ch]    = lat;
    e.ptr = ptr;
    e.vec = IQ_ENTRIES'(1) << ptr;
    if (relAt > 0) begin
      e.cyc = cyc + relAt;
      relQ[ch].push_back(e);
    end
    if (wakeAt > 0) begin
      e.cyc = cyc + wakeAt;
      wakeQ[ch].push_back(e);
    end
  endtask

  // Monitor: on every falling edge match each channel's wakeup and release against the queues.
  task automatic runMonitor();
    forever begin
      @(negedge clk);
      if (monOn) begin
        for (int c = 0; c < NUM_CH; c++) begin
          logic [CH_W-1:0] ci;
          ci = CH_W'(c);
          if (wakeup[ci]) begin
            if (wakeQ[ci].size() == 0 || wakeQ[ci][0].cyc != cyc) begin
              tests++;
              failed++;
              $display("[TB] FAIL wakeup ch%0d: got wakeup=1 ptr=%0d, expected wakeup=0 (cycle %0d)",
                       c, wakeupPtr[ci], cyc);
              if (wakeQ[ci].size() != 0 && wakeQ[ci][0].cyc < cyc) void'(wakeQ[ci].pop_front());
            end else begin
              checkOutput($sformatf("wakeupPtr ch%0d", c), 64'(wakeupPtr[ci]), 64'(wakeQ[ci][0].ptr));
              checkOutput($sformatf("wakeupVector ch%0d", c), 64'(wakeupVector[ci]), 64'(wakeQ[ci][0].vec));
              void'(wakeQ[ci].pop_front());
            end
          end else if (wakeQ[ci].size() != 0 && wakeQ[ci][0].cyc <= cyc) begin
            tests++;
            failed++;
            $display("[TB] FAIL wakeup ch%0d: got wakeup=0, expected wakeup=1 ptr=%0d (cycle %0d)",
                     c, wakeQ[ci][0].ptr, wakeQ[ci][0].cyc);
            void'(wakeQ[ci].pop_front());
          end
          if (releaseEntry[ci]) begin
            if (relQ[ci].size() == 0 || relQ[ci][0].cyc != cyc) begin
              tests++;
              failed++;
              $display("[TB] FAIL release ch%0d: got releaseEntry=1 ptr=%0d, expected releaseEntry=0 (cycle %0d)",
                       c, releasePtr[ci], cyc);
              if (relQ[ci].size() != 0 && relQ[ci][0].cyc < cyc) void'(relQ[ci].pop_front());
            end else begin
              checkOutput($sformatf("releasePtr ch%0d", c), 64'(releasePtr[ci]), 64'(relQ[ci][0].ptr));
              void'(relQ[ci].pop_front());
            end
          end else if (relQ[ci].size() != 0 && relQ[ci][0].cyc <= cyc) begin
            tests++;
            failed++;
            $display("[TB] FAIL release ch%0d: got releaseEntry=0, expected releaseEntry=1 ptr=%0d (cycle %0d)",
                     c, relQ[ci][0].ptr, relQ[ci][0].cyc);
            void'(relQ[ci].pop_front());
          end
        end
      end
    end
  endtask

  // Directed sequence.
  initial begin
    tests  = 0;
    failed = 0;
    cyc    = 0;
    monOn  = 1'b0;
    rst    = 1'b0;
    clearInputs();
    fork
      runMonitor();
    join_none

    idle(2);
    checkOutput("reset wakeup", 64'(wakeup), 64'h0);
    checkOutput("reset releaseEntry", 64'(releaseEntry), 64'h0);
    checkOutput("reset collisionErr", 64'(collisionErr), 64'h0);
    checkOutput("reset wakeupPtr", 64'(wakeupPtr), 64'h0);
    checkOutput("reset wakeupVector", 64'(wakeupVector), 64'h0);
    checkOutput("reset latBusy", 64'(latBusy), 64'h0);
    rst   = 1'b1;
    monOn = 1'b1;
    tick();

    // Latency 1: release and wakeup both one cycle after select, vector 0x0020.
    applyStimulus(2'd0, 4'd5, 3'd1, 1, 1);
    tick();
    clearInputs();
    idle(4);

    // Latency 3 with one stall cycle: release withheld, wakeup pushed out to +4.
    applyStimulus(2'd1, 4'd3, 3'd3, 0, 4);
    tick();
    clearInputs();
    stall = 1'b1;
    applyStimulus(2'd2, 4'd9, 3'd1, 0, 0);
    tick();
    clearInputs();
    idle(6);

    // Collision: ptr=7 lat=2 lands behind ptr=2 lat=3 and is dropped, but still released.
    applyStimulus(2'd0, 4'd2, 3'd3, 1, 3);
    tick();
    clearInputs();
    applyStimulus(2'd0, 4'd7, 3'd2, 1, 0);
    #1;
    checkOutput("latBusy ch0 behind lat3", 64'(latBusy[0]), 64'h2);
    checkOutput("collisionErr before collision", 64'(collisionErr), 64'h0);
    tick();
    clearInputs();
    checkOutput("collisionErr after collision", 64'(collisionErr), 64'h1);
    idle(3);
    checkOutput("collisionErr sticky", 64'(collisionErr), 64'h1);
    idle(2);

    // Four channels, latencies 1..4, flush two cycles later kills ch2/ch3; concurrent select released only.
    for (int i = 0; i < NUM_CH; i++) begin
      applyStimulus(CH_W'(i), IDX_W'(10 + i), LAT_W'(i + 1), 1, (i < 2) ? i + 1 : 0);
    end
    tick();
    clearInputs();
    checkOutput("latBusy ch3 lat4 pending", 64'(latBusy[3]), 64'h4);
    tick();
    flush = 1'b1;
    applyStimulus(2'd0, 4'd1, 3'd1, 1, 0);
    tick();
    clearInputs();
    checkOutput("latBusy after flush", 64'(latBusy), 64'h0);
    idle(6);

    // Clamping: latency 0 behaves as 1, latency 7 as MAX_LAT.
    applyStimulus(2'd3, 4'd4, 3'd0, 1, 1);
    applyStimulus(2'd2, 4'd6, 3'd7, 1, 4);
    tick();
    clearInputs();
    idle(6);

    // Asynchronous reset mid-cycle with three wakeups in flight.
    applyStimulus(2'd0, 4'd8, 3'd4, 1, 0);
    applyStimulus(2'd1, 4'd9, 3'd3, 1, 0);
    applyStimulus(2'd2, 4'd11, 3'd4, 1, 0);
    tick();
    clearInputs();
    checkOutput("latBusy ch0 before reset", 64'(latBusy[0]), 64'h4);
    checkOutput("latBusy ch1 before reset", 64'(latBusy[1]), 64'h2);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async reset wakeup", 64'(wakeup), 64'h0);
    checkOutput("async reset releaseEntry", 64'(releaseEntry), 64'h0);
    checkOutput("async reset collisionErr", 64'(collisionErr), 64'h0);
    checkOutput("async reset wakeupPtr", 64'(wakeupPtr), 64'h0);
    checkOutput("async reset wakeupVector", 64'(wakeupVector), 64'h0);
    checkOutput("async reset latBusy", 64'(latBusy), 64'h0);
    tick();
    rst = 1'b1;
    idle(8);
    checkOutput("collisionErr after reset", 64'(collisionErr), 64'h0);

    monOn = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      while (wakeQ[c].size() != 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL wakeup ch%0d: got no wakeup, expected ptr=%0d at cycle %0d",
                 c, wakeQ[c][0].ptr, wakeQ[c][0].cyc);
        void'(wakeQ[c].pop_front());
      end
      while (relQ[c].size() != 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL release ch%0d: got no release, expected ptr=%0d at cycle %0d",
                 c, relQ[c][0].ptr, relQ[c][0].cyc);
        void'(relQ[c].pop_front());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
